seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//  Upstream feeder for the BCD-to-7-segment decoder: time-multiplexes a packed multi-digit BCD value
//  onto a single 4-bit digit code plus active-low one-hot digit selects.
//  Double-buffers the displayed value so a frame never shows mixed old/new digits.
//  Adds anti-ghosting guard time, leading-zero blanking and invalid-code (>9) blanking.
// PARAMETERS
//  NUM_DIGITS    4     number of multiplexed digits; digit 0 = least significant (>=2)
//  PRESCALE      1000  clk cycles per digit slot (>= BLANK_CYCLES+1)
//  BLANK_CYCLES  2     cycles at start of each slot with all selects off (0 allowed)
// PORTS
//  clk          in   1             system clock, rising edge
//  rst_n        in   1             asynchronous active-low reset
//  en           in   1             scan enable; 0 = freeze counters, display dark
//  load         in   1             1-cycle strobe: capture value into staging register
//  value        in   4*NUM_DIGITS  packed BCD, nibble k = digit k
//  lz_blank     in   1             1 = suppress leading zeros
//  digit_code   out  4             BCD code of current digit, to decoder input i
//  digit_sel_n  out  NUM_DIGITS    active-low one-hot digit enable (all 1 = dark)
//  blank        out  1             1 = current slot dark; decoder output to be ignored
//  frame_done   out  1             1-cycle pulse at end of last digit slot
//  load_ack     out  1             1-cycle pulse when staged value becomes the displayed value
// BEHAVIOUR
//  Reset (async, rst_n=0): presc=0, idx=0, stage=0, shadow=0, pending=0; digit_sel_n=all 1,
//   digit_code=0, blank=1, frame_done=0, load_ack=0. Assert mid-scan -> outputs at reset values at once.
//  Prescaler: counts 0..PRESCALE-1 while en=1, wraps to 0; tick = (presc==PRESCALE-1)&en.
//  Digit index: idx++ on tick, wraps NUM_DIGITS-1 -> 0.
//   boundary = tick & idx==NUM_DIGITS-1; frame_done registered pulse on boundary.
//  Load: on load, stage<=value, pending<=1. Repeated loads before boundary: latest wins,
//   exactly one load_ack.
//  Shadow update: on boundary with pending: shadow<=stage, pending<=0, load_ack pulses.
//   load coincident with boundary: shadow<=value (bypass), pending stays 0, load_ack pulses.
//   en=0 with pending: shadow<=stage next cycle, load_ack pulses.
//  Slot dark (blank=1, digit_sel_n=all 1) when any of:
//   en=0 | presc<BLANK_CYCLES | shadow nibble[idx]>9
//   | (lz_blank & idx!=0 & shadow nibbles idx..NUM_DIGITS-1 all zero).
//  Otherwise blank=0, digit_sel_n = ~(1<<idx).
//  digit_code = shadow nibble[idx] always (also when dark).
//  Latency: all outputs registered; they reflect presc/idx/shadow of the previous cycle.
//  en deassert: dark next cycle; presc/idx hold; resume from the same presc/idx on re-enable.
//  value sampled only on load; value changes without load have no effect.
// STRUCTURE
//  Package seg7_pkg:
//   localparam DIGIT_W=4, BCD_MAX=4'd9;
//   function is_bcd(input [3:0]);
//   typedef digit_t = logic [3:0].
//  Sub-module seg7_prescaler (PRESCALE): presc count + tick; en gated; async rst_n.
//  Top: idx counter, stage/shadow/pending, blanking logic, output registers.
//  Decoder stays a separate downstream instance.
// TESTING (bench params NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2)
//  1 Reset: rst_n=0 mid-slot -> outputs at reset values same timestep; release -> idx=0, presc=0.
//  2 Normal scan: load 16'h1234, en=1 -> after first boundary load_ack=1; per frame:
//    code 4/3/2/1, sel 1110/1101/1011/0111; each lit 6 of 8 cycles; frame_done every 32 cycles.
//  3 Leading-zero blanking: lz_blank=1, load 16'h0045 -> digits 3,2 dark; 4,5 shown.
//    load 16'h0000 -> only digit 0 lit, shows 0. lz_blank=0 -> all four lit.
//  4 Invalid nibble: load 16'h12A4 -> digit 1 slot dark (blank=1); other digits normal.
//  5 Double buffering: load 16'h1111 then 16'h2222 mid-frame -> frame completes with old value;
//    next frame all 2; one load_ack. Load 16'h3333 on boundary cycle -> shown in the immediately
//    following frame (bypass).
//  6 Enable: en=0 mid-slot -> dark next cycle, idx/presc frozen; load 16'h5678 -> load_ack
//    within 2 cycles; en=1 -> scan resumes from frozen idx/presc showing 5678.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared digit types and BCD helpers for the 7-segment scan path.
package seg7_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] digit_t;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Slot-rate prescaler: free-running modulo-PRESCALE count that freezes while en=0.
module seg7_prescaler #(
    parameter int  PRESCALE = 1000,
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [PW-1:0] presc,
    output logic          tick
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    assign tick = en && (presc == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else if (en) begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexes a double-buffered packed BCD value onto one digit code plus
// active-low digit selects, with guard time, leading-zero and invalid-code blanking.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic                          lz_blank,
    output digit_t                        digit_code,
    output logic [NUM_DIGITS-1:0]         digit_sel_n,
    output logic                          blank,
    output logic                          frame_done,
    output logic                          load_ack
);

    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int             IW       = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]               presc;
    logic                        tick;
    logic [IW-1:0]               idx;
    digit_t [NUM_DIGITS-1:0]     stage;
    digit_t [NUM_DIGITS-1:0]     shadow;
    logic                        pending;
    logic                        boundary;
    logic                        in_guard;
    logic                        upper_zero;
    logic                        dark;
    digit_t                      cur;

    seg7_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .presc (presc),
        .tick  (tick)
    );

    assign boundary = tick && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // The shadow only changes at a frame boundary or while the display is dark,
    // so a visible frame never mixes digits from two loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage    <= '0;
            shadow   <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (load) begin
                stage <= value;
            end
            if (boundary) begin
                if (load) begin
                    shadow   <= value;
                    load_ack <= 1'b1;
                end else if (pending) begin
                    shadow   <= stage;
                    load_ack <= 1'b1;
                end
                pending <= 1'b0;
            end else if (!en && pending) begin
                shadow   <= stage;
                load_ack <= 1'b1;
                pending  <= load;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    generate
        if (BLANK_CYCLES > 0) begin : g_guard
            assign in_guard = presc < PW'(BLANK_CYCLES);
        end else begin : g_no_guard
            assign in_guard = 1'b0;
        end
    endgenerate

    assign cur = shadow[idx];

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && shadow[k] != '0) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign dark = !en || in_guard || !is_bcd(cur) || (lz_blank && (idx != '0) && upper_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_code  <= '0;
            digit_sel_n <= '1;
            blank       <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            digit_code  <= cur;
            digit_sel_n <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
            blank       <= dark;
            frame_done  <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: a frame-position reference model queues the
// expected outputs of every clock edge and a negedge monitor compares them.
module tb_seg7_scan_mux;

    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;
    localparam int FRAME = N * P;

    typedef struct packed {
        logic [3:0]   code;
        logic [N-1:0] sel;
        logic         blank;
        logic         fd;
        logic         ack;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [4*N-1:0] value = '0;
    logic          lz_blank = 1'b0;
    logic [3:0]    digit_code;
    logic [N-1:0]  digit_sel_n;
    logic          blank;
    logic          frame_done;
    logic          load_ack;

    int checks = 0;
    int errors = 0;

    exp_t        expq[$];
    int          pos = 0;
    int unsigned disp = 0;
    int unsigned stg = 0;
    bit          pend = 1'b0;
    int          lit_cnt[N];

    seg7_scan_mux #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .value       (value),
        .lz_blank    (lz_blank),
        .digit_code  (digit_code),
        .digit_sel_n (digit_sel_n),
        .blank       (blank),
        .frame_done  (frame_done),
        .load_ack    (load_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one position counter over the whole frame, arithmetic on the displayed value.
    task automatic model_edge();
        exp_t        e;
        int          slot;
        int          ph;
        int unsigned upper;
        int unsigned nib;
        bit          dk;
        bit          bnd;
        slot  = pos / P;
        ph    = pos % P;
        upper = disp >> (4 * slot);
        nib   = upper & 32'hF;
        dk    = !en || (ph < B) || (nib > 9) || (lz_blank && slot != 0 && upper == 0);
        bnd   = en && (pos == FRAME - 1);
        e.code  = nib[3:0];
        e.sel   = dk ? {N{1'b1}} : ~(N'(1) << slot);
        e.blank = dk;
        e.fd    = bnd;
        e.ack   = 1'b0;
        if (bnd) begin
            if (load) begin
                disp  = value;
                e.ack = 1'b1;
            end else if (pend) begin
                disp  = stg;
                e.ack = 1'b1;
            end
            pend = 1'b0;
        end else if (!en && pend) begin
            disp  = stg;
            e.ack = 1'b1;
            pend  = load;
        end else if (load) begin
            pend = 1'b1;
        end
        if (load) stg = value;
        if (en) pos = (pos + 1) % FRAME;
        expq.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pos  = 0;
                disp = 0;
                stg  = 0;
                pend = 1'b0;
                expq.delete();
            end else begin
                model_edge();
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || expq.size() == 0) begin
                e = '{code: 4'h0, sel: {N{1'b1}}, blank: 1'b1, fd: 1'b0, ack: 1'b0};
            end else begin
                e = expq.pop_front();
            end
            chk("digit_code", digit_code, e.code);
            chk("digit_sel_n", digit_sel_n, e.sel);
            chk("blank", blank, e.blank);
            chk("frame_done", frame_done, e.fd);
            chk("load_ack", load_ack, e.ack);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4*N-1:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        while (pos != target && n < 2 * FRAME) begin
            step();
            n++;
        end
        if (pos != target) chk("wait_pos", pos, target);
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (!load_ack && n < 3 * FRAME) begin
            step();
            n++;
        end
        chk("ack_seen", load_ack, 1);
    endtask

    // Syncs to a frame_done pulse, then tallies lit cycles per digit over one frame.
    task automatic count_frame(output int period);
        int n;
        n = 0;
        while (!frame_done && n < 3 * FRAME) begin
            step();
            n++;
        end
        chk("frame_sync", frame_done, 1);
        for (int k = 0; k < N; k++) lit_cnt[k] = 0;
        period = 0;
        for (int c = 1; c <= FRAME + 1; c++) begin
            step();
            if (c <= FRAME) begin
                for (int k = 0; k < N; k++)
                    if (digit_sel_n == ~(N'(1) << k)) lit_cnt[k]++;
            end
            if (frame_done && period == 0) period = c;
        end
    endtask

    function automatic logic [4*N-1:0] rnd_value();
        logic [4*N-1:0] v;
        int pick;
        v = '0;
        for (int k = 0; k < N; k++) begin
            pick = $urandom_range(0, 15);
            if (pick < 4)       v[4*k +: 4] = 4'h0;
            else if (pick < 14) v[4*k +: 4] = 4'($urandom_range(1, 9));
            else                v[4*k +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    initial begin
        int per;
        int acks;
        int bad_code;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Normal scan of 1234.
        en = 1'b1;
        do_load(16'h1234);
        wait_ack();
        count_frame(per);
        chk("frame_period", per, FRAME);
        for (int k = 0; k < N; k++) chk($sformatf("lit_1234_d%0d", k), lit_cnt[k], P - B);
        bad_code = 0;
        for (int c = 0; c < FRAME; c++) begin
            step();
            for (int k = 0; k < N; k++)
                if (digit_sel_n == ~(N'(1) << k) && digit_code != 4'(4 - k)) bad_code++;
        end
        chk("code_1234", bad_code, 0);

        // Asynchronous reset in the middle of a slot.
        wait_pos(13);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_sel", digit_sel_n, {N{1'b1}});
        chk("rst_blank", blank, 1);
        chk("rst_code", digit_code, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_ack", load_ack, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Leading-zero blanking.
        lz_blank = 1'b1;
        do_load(16'h0045);
        wait_ack();
        count_frame(per);
        chk("lz_0045_d0", lit_cnt[0], P - B);
        chk("lz_0045_d1", lit_cnt[1], P - B);
        chk("lz_0045_d2", lit_cnt[2], 0);
        chk("lz_0045_d3", lit_cnt[3], 0);
        do_load(16'h0000);
        wait_ack();
        count_frame(per);
        chk("lz_0000_d0", lit_cnt[0], P - B);
        chk("lz_0000_rest", lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);
        lz_blank = 1'b0;
        count_frame(per);
        for (int k = 0; k < N; k++) chk($sformatf("nolz_d%0d", k), lit_cnt[k], P - B);

        // Invalid nibble blanks its own slot only.
        do_load(16'h12A4);
        wait_ack();
        count_frame(per);
        chk("inv_d0", lit_cnt[0], P - B);
        chk("inv_d1", lit_cnt[1], 0);
        chk("inv_d2", lit_cnt[2], P - B);
        chk("inv_d3", lit_cnt[3], P - B);

        // Double buffering: two loads in one frame give one ack; bypass on boundary.
        wait_pos(2);
        do_load(16'h1111);
        repeat (3) step();
        do_load(16'h2222);
        acks = 0;
        for (int c = 0; c < FRAME + 8; c++) begin
            step();
            if (load_ack) acks++;
        end
        chk("double_load_acks", acks, 1);
        wait_pos(FRAME - 1);
        do_load(16'h3333);
        chk("bypass_ack", load_ack, 1);
        count_frame(per);

        // Enable freeze with a load while dark.
        wait_pos(10);
        en = 1'b0;
        repeat (2) step();
        chk("dis_dark", blank, 1);
        do_load(16'h5678);
        acks = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (load_ack) acks++;
        end
        chk("dis_load_ack", acks, 1);
        chk("frozen_pos", pos, 10);
        en = 1'b1;
        count_frame(per);
        for (int k = 0; k < N; k++) chk($sformatf("resume_d%0d", k), lit_cnt[k], P - B);

        // Randomized traffic; every cycle is checked by the scoreboard.
        for (int c = 0; c < 1500; c++) begin
            en    = ($urandom_range(0, 15) != 0);
            value = rnd_value();
            load  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
            step();
        end
        load = 1'b0;
        en   = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
